// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  // Fetch sequencing phases: issuing a request, awaiting its response,
  // holding a buffered word for the cpu.
  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_t;

  // Sequencer control word: current phase plus the squash flag for an
  // in-flight response that a redirect has made stale.
  typedef struct packed {
    fetch_state_t state;
    logic         drop;
  } control_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of the instruction-memory request/response and cpu-side signals.
// master = fetch sequencer side, slave = memory/cpu side.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int XLEN = fetch_ctrl_pkg::XLEN
) ();

  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;
  logic               instr_ready;
  logic               redirect;
  logic [XLEN-1:0]    redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
           redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps at most one memory
// request outstanding, buffers the returned word for the cpu and squashes
// in-flight or buffered fetches when the cpu redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int              XLEN     = fetch_ctrl_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  control_t           ctrl, ctrl_next;
  logic [XLEN-1:0]    fetch_pc, fetch_pc_next;
  logic [XLEN-1:0]    req_pc, req_pc_next;
  logic [INSTR_W-1:0] instr_word, instr_word_next;
  logic [XLEN-1:0]    instr_addr, instr_addr_next;
  logic               req_valid;
  logic               accept;

  // State register; reset takes effect immediately, not at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl.state <= S_REQ;
      ctrl.drop  <= 1'b0;
      fetch_pc   <= RESET_PC;
      req_pc     <= '0;
      instr_word <= '0;
      instr_addr <= '0;
    end else begin
      ctrl       <= ctrl_next;
      fetch_pc   <= fetch_pc_next;
      req_pc     <= req_pc_next;
      instr_word <= instr_word_next;
      instr_addr <= instr_addr_next;
    end
  end

  // Outputs and next-state decode; a redirect overrides every other event.
  always_comb begin
    ctrl_next       = ctrl;
    fetch_pc_next   = fetch_pc;
    req_pc_next     = req_pc;
    instr_word_next = instr_word;
    instr_addr_next = instr_addr;

    // The request is masked during reset so nothing escapes before release.
    req_valid = (ctrl.state == S_REQ) && !rst;
    accept    = req_valid && bus.mem_req_ready;

    bus.mem_req_valid = req_valid;
    bus.mem_req_addr  = fetch_pc;
    bus.instr_valid   = (ctrl.state == S_HOLD);
    bus.instr         = instr_word;
    bus.instr_pc      = instr_addr;

    case (ctrl.state)
      S_REQ: begin
        if (accept) begin
          req_pc_next     = fetch_pc;
          ctrl_next.state = S_WAIT;
          // Accepted in the same cycle as a redirect: already stale.
          ctrl_next.drop  = bus.redirect;
        end
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          ctrl_next.state = S_REQ;
          ctrl_next.drop  = 1'b0;
          if (!ctrl.drop && !bus.redirect) begin
            instr_word_next = bus.mem_rsp_data;
            instr_addr_next = req_pc;
            fetch_pc_next   = req_pc + XLEN'(4);
            ctrl_next.state = S_HOLD;
          end
        end else if (bus.redirect) begin
          ctrl_next.drop = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect squashes the word even if the cpu takes it this cycle.
        if (bus.redirect || bus.instr_ready) begin
          ctrl_next.state = S_REQ;
        end
      end
      default: begin
        ctrl_next.state = S_REQ;
        ctrl_next.drop  = 1'b0;
      end
    endcase

    if (bus.redirect) begin
      fetch_pc_next = {bus.redirect_pc[XLEN-1:2], 2'b00};
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model
// (one outstanding fetch, one buffered word, a next-fetch address).
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.XLEN(64)) bus ();

  fetch_ctrl #(.XLEN(64), .RESET_PC(64'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model of what the fetcher must be doing.
  bit          m_out   = 1'b0;   // a request is outstanding
  bit          m_stale = 1'b0;   // its response must be discarded
  logic [63:0] m_addr  = '0;     // address of the outstanding request
  bit          m_held  = 1'b0;   // a word is presented to the cpu
  logic [31:0] m_data  = '0;
  logic [63:0] m_ipc   = '0;
  logic [63:0] m_pc    = '0;     // next address to request
  int          accepts  = 0;
  int          consumed = 0;

  // Memory-side response scheduler.
  bit          pending  = 1'b0;
  int          cnt      = 0;
  logic [63:0] pend_addr = '0;
  int          cur_dly  = 1;
  bit          poison   = 1'b0;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    if (a == 64'h0) return 32'h00500093;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge.
  task automatic step(input bit rdy, input bit irdy, input bit redir,
                      input logic [63:0] rpc, input int dly, input bit spur);
    @(negedge clk);
    bus.mem_req_ready = rdy;
    bus.instr_ready   = irdy;
    bus.redirect      = redir;
    bus.redirect_pc   = rpc;
    cur_dly           = dly;
    if (rst) begin
      pending           = 1'b0;
      bus.mem_rsp_valid = 1'b0;
    end else if (pending && cnt == 0) begin
      pending           = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = poison ? 32'hDEADBEEF : word_at(pend_addr);
    end else begin
      if (pending) cnt--;
      bus.mem_rsp_valid = spur && !pending && ($urandom_range(9) == 0);
      bus.mem_rsp_data  = $urandom;
    end
  endtask

  // Model update at each rising edge from the inputs the DUT sees.
  always @(posedge clk) begin
    bit          hs, rsp, cons;
    logic [63:0] old_pc;
    if (rst) begin
      m_out = 0; m_stale = 0; m_held = 0; m_pc = 64'h0; pending = 0;
    end else begin
      hs     = !m_out && !m_held && bus.mem_req_ready;
      rsp    = m_out && bus.mem_rsp_valid;
      cons   = m_held && bus.instr_ready;
      old_pc = m_pc;
      if (hs) begin
        accepts++;
        pending   = 1'b1;
        cnt       = cur_dly - 1;
        pend_addr = old_pc;
      end
      if (bus.redirect) begin
        m_pc   = {bus.redirect_pc[63:2], 2'b00};
        m_held = 1'b0;
        if (rsp) m_out = 1'b0;
        else if (m_out) m_stale = 1'b1;
        if (hs) begin m_out = 1'b1; m_stale = 1'b1; m_addr = old_pc; end
      end else begin
        if (hs) begin m_out = 1'b1; m_stale = 1'b0; m_addr = old_pc; end
        if (rsp) begin
          m_out = 1'b0;
          if (!m_stale) begin
            m_held = 1'b1;
            m_data = bus.mem_rsp_data;
            m_ipc  = m_addr;
            m_pc   = m_addr + 64'd4;
          end
        end else if (cons) begin
          m_held = 1'b0;
          consumed++;
          $display("[TB] instr pc=%h word=%h", m_ipc, m_data);
        end
      end
    end
  end

  // Compare DUT outputs with the model every cycle on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid",   {63'b0, bus.mem_req_valid}, 64'd0);
      chk("rst_instr_valid", {63'b0, bus.instr_valid},   64'd0);
      chk("rst_instr",       {32'b0, bus.instr},         64'd0);
      chk("rst_instr_pc",    bus.instr_pc,               64'd0);
    end else begin
      chk("req_valid", {63'b0, bus.mem_req_valid}, {63'b0, (!m_out && !m_held)});
      if (!m_out && !m_held) chk("req_addr", bus.mem_req_addr, m_pc);
      chk("instr_valid", {63'b0, bus.instr_valid}, {63'b0, m_held});
      if (m_held) begin
        chk("instr",    {32'b0, bus.instr}, {32'b0, m_data});
        chk("instr_pc", bus.instr_pc, m_ipc);
      end
    end
  end

  initial begin
    bus.mem_req_ready = 0; bus.instr_ready = 0; bus.redirect = 0;
    bus.redirect_pc = '0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;

    // Reset held, then released away from the clock edge.
    repeat (3) begin
      step(0, 0, 0, 0, 1, 0);
      #1 chk("t1_rst_no_req", {63'b0, bus.mem_req_valid}, 64'd0);
    end
    @(posedge clk); #2 rst = 1'b0;

    // First fetch from address 0, zero-wait memory.
    step(1, 1, 0, 0, 1, 0);
    #1 chk("t1_first_valid", {63'b0, bus.mem_req_valid}, 64'd1);
    chk("t1_first_addr", bus.mem_req_addr, 64'h0);
    step(0, 1, 0, 0, 1, 0);
    #1 chk("t2_wait_no_req", {63'b0, bus.mem_req_valid}, 64'd0);
    step(0, 1, 0, 0, 1, 0);
    #1 chk("t2_instr_valid", {63'b0, bus.instr_valid}, 64'd1);
    chk("t2_instr", {32'b0, bus.instr}, 64'h00500093);
    chk("t2_instr_pc", bus.instr_pc, 64'h0);

    // Memory stalls the request to 0x4 for 4 cycles.
    repeat (4) begin
      step(0, 0, 0, 0, 1, 0);
      #1 chk("t3_stall_addr", bus.mem_req_addr, 64'h4);
    end
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // cpu stalls the buffered word for 5 cycles.
    repeat (5) begin
      step(0, 0, 0, 0, 1, 0);
      #1 chk("t4_hold_valid", {63'b0, bus.instr_valid}, 64'd1);
      chk("t4_hold_pc", bus.instr_pc, 64'h4);
      chk("t4_hold_no_req", {63'b0, bus.mem_req_valid}, 64'd0);
    end
    chk("t3_one_accept", 64'(accepts), 64'd2);
    step(0, 1, 0, 0, 1, 0);

    // Redirect back to 0x4, then squash its fetch while in flight.
    step(0, 0, 1, 64'h4, 1, 0);
    #1 chk("t2_next_addr8", bus.mem_req_addr, 64'h8);
    poison = 1'b1;
    step(1, 0, 0, 0, 3, 0);
    #1 chk("t5_req_addr4", bus.mem_req_addr, 64'h4);
    step(0, 0, 1, 64'h103, 1, 0);
    repeat (2) begin
      step(0, 0, 0, 0, 1, 0);
      #1 chk("t5_no_instr", {63'b0, bus.instr_valid}, 64'd0);
    end
    step(0, 0, 0, 0, 1, 0);
    #1 chk("t5_redir_addr", bus.mem_req_addr, 64'h100);
    chk("t5_squashed", {63'b0, bus.instr_valid}, 64'd0);
    poison = 1'b0;
    step(1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);

    // Redirect and consume in the same cycle while holding.
    step(0, 1, 1, 64'h200, 1, 0);
    #1 chk("t5_instr_pc", bus.instr_pc, 64'h100);
    step(0, 0, 0, 0, 1, 0);
    #1 chk("t6_squash", {63'b0, bus.instr_valid}, 64'd0);
    chk("t6_req_addr", bus.mem_req_addr, 64'h200);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    #1 chk("wrap_addr", bus.mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0);
    #1 chk("wrap_instr_pc", bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 1, 0);
    #1 chk("wrap_next", bus.mem_req_addr, 64'h0);

    // Asynchronous reset while a fetch is in flight.
    step(1, 0, 0, 0, 4, 0);
    step(0, 0, 0, 0, 1, 0);
    #3 rst = 1'b1;
    #1 chk("arst_req_valid", {63'b0, bus.mem_req_valid}, 64'd0);
    chk("arst_instr_valid", {63'b0, bus.instr_valid}, 64'd0);
    chk("arst_instr", {32'b0, bus.instr}, 64'd0);
    chk("arst_instr_pc", bus.instr_pc, 64'd0);
    repeat (2) step(0, 0, 0, 0, 1, 0);
    @(posedge clk); #2 rst = 1'b0;

    // Randomized traffic checked every cycle by the compare process.
    consumed = 0;
    repeat (3000) begin
      step($urandom_range(9) < 7, $urandom_range(9) < 6, $urandom_range(99) < 8,
           {$urandom, $urandom}, int'($urandom_range(4, 1)), 1);
    end
    chk("rand_progress", {63'b0, (consumed > 100)}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
